trail_writer: RTL and testbench

- Write-side master for the packed 4-bit-per-pixel frame buffer (640x480, two pixels per 8-bit word).
- Accepts single-pixel paint requests (x, y, colour enum) from the bike/game logic over a valid/ready handshake.
- Performs a read-modify-write so the neighbouring pixel in the same word is preserved.
- Also provides a full-screen clear sweep used at game start/restart.

---
 rtl/tron_pkg.sv | 38 +++
 rtl/fb_addr_calc.sv | 19 +
 rtl/trail_writer.sv | 141 ++++++++++++++
 tb/tb_trail_writer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// Shared definitions for the packed 4bpp frame buffer: geometry, colour
// enum, writer FSM states and the nibble merge used by read-modify-write.
package tron_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int FB_WORDS = H_RES * V_RES / 2;
  localparam int ADDR_W   = 19;

  typedef enum logic [3:0] {
    COL_BG       = 4'h0,
    COL_WALL     = 4'h1,
    COL_P1_TRAIL = 4'h2,
    COL_P1_HEAD  = 4'h3,
    COL_P2_TRAIL = 4'h4,
    COL_P2_HEAD  = 4'h5,
    COL_CRASH    = 4'hE,
    COL_TEXT     = 4'hF
  } color_e;

  localparam color_e CLEAR_COLOR = COL_BG;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_CLEAR
  } tw_state_e;

  // Replace one pixel of a packed word; even x lives in the high nibble.
  function automatic logic [7:0] merge_nibble(input logic [7:0] word,
                                              input logic       lo,
                                              input logic [3:0] col);
    return lo ? {word[7:4], col} : {col, word[3:0]};
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Pixel (x, y) to packed word address and nibble select. The row stride
// is 320 words (640 pixels, two per byte) built from shifts so the
// display read path can share the same block without a multiplier.
module fb_addr_calc import tron_pkg::*; #(
  parameter int AW = ADDR_W
) (
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [AW-1:0] word_addr,
  output logic          nib_lo
);

  // y*320 + x/2, low bit of x picks the nibble
  always_comb begin
    word_addr = (AW'(y) << 8) + (AW'(y) << 6) + AW'(x[9:1]);
    nib_lo    = x[0];
  end

endmodule

// File: rtl/trail_writer.sv
// Write-side master for the packed frame buffer: single-pixel paints by
// read-modify-write, plus a full-screen clear sweep.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a paint request or a clear
// ST_RD    | read address presented for the latched pixel's word
// ST_WAIT  | RAM data valid, merged byte registered
// ST_WR    | merged byte written back (one cycle)
// ST_CLEAR | writing background to every word, one per cycle
module trail_writer import tron_pkg::*; #(
  parameter int     H_RES       = tron_pkg::H_RES,
  parameter int     V_RES       = tron_pkg::V_RES,
  parameter int     ADDR_W      = tron_pkg::ADDR_W,
  parameter color_e CLEAR_COLOR = tron_pkg::CLEAR_COLOR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  logic [3:0]        req_color,
  input  logic              clear_req,
  output logic              clear_done,
  output logic              busy,
  output logic [ADDR_W-1:0] read_address,
  input  logic [7:0]        ram_data_out,
  output logic [ADDR_W-1:0] write_address,
  output logic [7:0]        ram_data_in,
  output logic              we
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(H_RES * V_RES / 2 - 1);

  tw_state_e         state_q, state_d;
  logic [9:0]        x_q, y_q;
  color_e            col_q;
  logic [7:0]        merged_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              clear_pend_q;
  logic              clear_done_q;
  logic [ADDR_W-1:0] word_addr;
  logic              nib_lo;
  logic              ready_int;
  logic              accept;
  logic              req_in_range;

  fb_addr_calc #(.AW(ADDR_W)) u_addr (
    .x         (x_q),
    .y         (y_q),
    .word_addr (word_addr),
    .nib_lo    (nib_lo)
  );

  // Range test on the request itself; it is what gets latched on accept.
  always_comb begin
    req_in_range = (int'(req_x) < H_RES) && (int'(req_y) < V_RES);
  end

  // Next-state logic; a clear always wins over a paint request in IDLE.
  always_comb begin
    state_d   = state_q;
    ready_int = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req || clear_pend_q) begin
          state_d = ST_CLEAR;
        end else begin
          ready_int = 1'b1;
          if (req_valid) begin
            accept = 1'b1;
            if (req_in_range) state_d = ST_RD;
          end
        end
      end
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_WR;
      ST_WR:   state_d = (clear_req || clear_pend_q) ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: begin
        if (cnt_q == LAST_WORD) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; RAM strobes come straight from state so reset kills them at once.
  always_comb begin
    req_ready     = rst_n && ready_int;
    busy          = (state_q != ST_IDLE);
    we            = (state_q == ST_WR) || (state_q == ST_CLEAR);
    read_address  = word_addr;
    write_address = (state_q == ST_CLEAR) ? cnt_q : word_addr;
    ram_data_in   = (state_q == ST_CLEAR) ? {CLEAR_COLOR, CLEAR_COLOR} : merged_q;
    clear_done    = clear_done_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request latch and merged-byte register for the read-modify-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= COL_BG;
      merged_q <= '0;
    end else begin
      if (accept) begin
        x_q   <= req_x;
        y_q   <= req_y;
        col_q <= color_e'(req_color);
      end
      if (state_q == ST_WAIT) merged_q <= merge_nibble(ram_data_out, nib_lo, col_q);
    end
  end

  // Clear sweep counter, deferred-clear flag and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      clear_pend_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      if (state_d == ST_CLEAR && state_q != ST_CLEAR) cnt_q <= '0;
      else if (state_q == ST_CLEAR)                   cnt_q <= cnt_q + 1'b1;

      if (state_d == ST_CLEAR)
        clear_pend_q <= 1'b0;
      else if (clear_req && (state_q == ST_RD || state_q == ST_WAIT))
        clear_pend_q <= 1'b1;

      clear_done_q <= (state_q == ST_CLEAR) && (cnt_q == LAST_WORD);
    end
  end

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer. A pixel-level model (one colour per
// pixel) predicts every RAM write; the monitor pops and compares on we.
// The DUT is built with a short screen (16 lines) so a clear sweep stays short.
module tb_trail_writer;

  localparam int H     = 640;
  localparam int VT    = 16;
  localparam int WORDS = H * VT / 2;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_x, req_y;
  logic [3:0]  req_color;
  logic        clear_req;
  logic        clear_done;
  logic        busy;
  logic [18:0] read_address;
  logic [7:0]  ram_data_out;
  logic [18:0] write_address;
  logic [7:0]  ram_data_in;
  logic        we;

  logic [7:0]  ram      [0:WORDS-1];
  logic [7:0]  init_mem [0:WORDS-1];
  logic        load_en;
  logic [3:0]  pix      [0:H*VT-1];

  wr_t         exp_q [$];
  int          done_q [$];
  wr_t         mon_e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  trail_writer #(.V_RES(VT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_color     (req_color),
    .clear_req     (clear_req),
    .clear_done    (clear_done),
    .busy          (busy),
    .read_address  (read_address),
    .ram_data_out  (ram_data_out),
    .write_address (write_address),
    .ram_data_in   (ram_data_in),
    .we            (we)
  );

  // Synchronous frame RAM, one-cycle read latency
  always @(posedge clk) begin
    if (load_en) begin
      ram <= init_mem;
    end else if (we && rst_n && int'(write_address) < WORDS) begin
      ram[write_address] <= ram_data_in;
    end
    ram_data_out <= (int'(read_address) < WORDS) ? ram[read_address] : 8'h00;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_of(input int w);
    return {pix[2*w], pix[2*w+1]};
  endfunction

  // Monitor: every write and every clear_done must match the next expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {13'd0, write_address}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {13'd0, write_address}, {13'd0, mon_e.addr});
          check("wr_data", {24'd0, ram_data_in}, {24'd0, mon_e.data});
          check("wr_cycle", cyc, mon_e.cyc);
        end
      end
      if (clear_done) begin
        if (done_q.size() == 0) check("unexpected_clear_done", cyc, 32'hFFFF_FFFF);
        else                    check("clear_done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic drive_pt();
    @(negedge clk);
    #2;
  endtask

  task automatic start_req(input int x, input int y, input int c);
    req_x     = 10'(x);
    req_y     = 10'(y);
    req_color = 4'(c);
    req_valid = 1'b1;
  endtask

  // Wait for the handshake, update the pixel model, then drop valid in the RD cycle
  task automatic wait_accept();
    int n = 0;
    int k, x, y, idx, w;
    bit inr;
    while (!req_ready && n < 20000) begin
      drive_pt();
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", n, 0);
      req_valid = 1'b0;
      return;
    end
    k   = cyc;
    x   = int'(req_x);
    y   = int'(req_y);
    inr = (x < H) && (y < VT);
    w   = 0;
    if (inr) begin
      idx      = y * H + x;
      pix[idx] = req_color;
      w        = idx / 2;
      exp_q.push_back({19'(w), word_of(w), 32'(k + 3)});
    end
    drive_pt();
    req_valid = 1'b0;
    if (inr) check("rd_addr", {13'd0, read_address}, w);
    else     check("oor_stays_idle", {31'd0, busy}, 0);
  endtask

  task automatic paint(input int x, input int y, input int c);
    start_req(x, y, c);
    wait_accept();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20000) begin
      drive_pt();
      n++;
    end
    check("idle_reached", {31'd0, busy}, 0);
  endtask

  task automatic push_clear(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      pix[2*i]   = 4'h0;
      pix[2*i+1] = 4'h0;
      exp_q.push_back({19'(i), 8'h00, 32'(base + i)});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, k, px, py, errs;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_color = '0;
    clear_req = 1'b0;
    for (int i = 0; i < WORDS; i++) init_mem[i] = 8'($urandom);
    init_mem[1605] = 8'hAB;
    for (int i = 0; i < WORDS; i++) begin
      pix[2*i]   = init_mem[i][7:4];
      pix[2*i+1] = init_mem[i][3:0];
    end
    load_en = 1'b1;
    drive_pt();
    load_en = 1'b0;
    drive_pt();

    check("rst_we", {31'd0, we}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, req_ready}, 0);
    check("rst_clear_done", {31'd0, clear_done}, 0);
    check("rst_read_address", {13'd0, read_address}, 0);
    check("rst_write_address", {13'd0, write_address}, 0);
    check("rst_wdata", {24'd0, ram_data_in}, 0);

    rst_n = 1'b1;
    drive_pt();
    check("ready_after_reset", {31'd0, req_ready}, 1);

    // Even, odd and back-to-back same-word paints
    paint(10, 5, 4'h3);
    paint(11, 5, 4'h7);
    paint(10, 5, 4'hC);

    // Out of range requests are accepted and dropped
    paint(640, 0, 4'h5);
    paint(0, 480, 4'h5);
    paint(0, VT, 4'h5);
    paint(1023, 1023, 4'h5);
    paint(639, VT - 1, 4'h9);

    // Random paints, often hitting the neighbour pixel of the previous one
    px = 0;
    py = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        px = px ^ 1;
      end else begin
        px = ($urandom_range(0, 19) == 0) ? int'($urandom_range(640, 1023)) : int'($urandom_range(0, 639));
        py = ($urandom_range(0, 19) == 0) ? int'($urandom_range(VT, 1023))  : int'($urandom_range(0, VT - 1));
      end
      paint(px, py, int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) drive_pt();
    end

    // Full clear with a second clear_req mid-sweep that must be ignored
    wait_idle();
    clear_req = 1'b1;
    k = cyc;
    push_clear(k + 1, WORDS);
    done_q.push_back(k + 1 + WORDS);
    drive_pt();
    clear_req = 1'b0;
    n = 0;
    while (!clear_done && n < WORDS + 50) begin
      check("ready_low_in_clear", {31'd0, req_ready}, 0);
      if (n == 100) clear_req = 1'b1;
      drive_pt();
      clear_req = 1'b0;
      n++;
    end
    check("clear_done_seen", {31'd0, clear_done}, 1);
    drive_pt();
    check("clear_done_one_cycle", {31'd0, clear_done}, 0);

    // Clear arriving in WAIT: pixel write first, then sweep; held request waits
    paint(20, 3, 4'h9);
    drive_pt();
    clear_req = 1'b1;
    push_clear(cyc + 2, WORDS);
    done_q.push_back(cyc + 2 + WORDS);
    start_req(30, 2, 4'h4);
    drive_pt();
    clear_req = 1'b0;
    n = 0;
    while (!clear_done && n < WORDS + 50) begin
      check("held_req_blocked", {31'd0, req_ready}, 0);
      drive_pt();
      n++;
    end
    check("clear2_done_seen", {31'd0, clear_done}, 1);
    wait_accept();

    // Reset in the middle of a sweep while counter is 1000
    wait_idle();
    clear_req = 1'b1;
    k = cyc;
    push_clear(k + 1, 1000);
    drive_pt();
    clear_req = 1'b0;
    repeat (999) drive_pt();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_we", {31'd0, we}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_clear_done", {31'd0, clear_done}, 0);
    repeat (3) begin
      drive_pt();
      check("no_done_in_reset", {31'd0, clear_done}, 0);
    end
    check("abort_pending_writes", exp_q.size(), 0);
    rst_n = 1'b1;
    drive_pt();
    check("ready_after_abort", {31'd0, req_ready}, 1);
    check("idle_after_abort", {31'd0, busy}, 0);

    paint(5, 7, 4'hE);
    paint(4, 7, 4'h2);
    for (int i = 0; i < 20; i++) paint(int'($urandom_range(0, 639)), int'($urandom_range(0, VT - 1)),
                                      int'($urandom_range(0, 15)));

    wait_idle();
    repeat (5) drive_pt();
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    errs = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== word_of(i)) errs++;
    check("ram_image_words_wrong", errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
